// File: rtl/cpu_sequencer_pkg.sv
// Shared types and field layout for the picoMIPS control unit.
// Instruction word is {op, rd, imm}; opcodes outside the enum decode as NOP.
package cpu_sequencer_pkg;

  localparam int unsigned N       = 8;
  localparam int unsigned R_SIZE  = 3;
  localparam int unsigned PC_SIZE = 5;
  localparam int unsigned OP_SIZE = 4;
  localparam int unsigned INSTR_W = OP_SIZE + R_SIZE + N;

  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_MSB = N - 1;
  localparam int unsigned RD_LSB  = N;
  localparam int unsigned RD_MSB  = N + R_SIZE - 1;
  localparam int unsigned OP_LSB  = N + R_SIZE;
  localparam int unsigned OP_MSB  = INSTR_W - 1;

  typedef enum logic [OP_SIZE-1:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_ADDI  = 4'd2,
    OP_SUB   = 4'd3,
    OP_SUBI  = 4'd4,
    OP_MUL   = 4'd5,
    OP_MULI  = 4'd6,
    OP_ADDSW = 4'd7,
    OP_BNZ   = 4'd8,
    OP_JMP   = 4'd9,
    OP_HALT  = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    EXECUTE,
    WAIT_PRESS,
    WAIT_RELEASE,
    HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } alu_func_t;

  typedef struct packed {
    opcode_t             op;
    logic [R_SIZE-1:0]   rd;
    logic [N-1:0]        imm;
  } instr_t;

  // ALU operation implied by an arithmetic opcode (reg-reg and immediate forms share it)
  function automatic alu_func_t alu_func_of(input opcode_t op);
    alu_func_t f;
    f = ALU_ADD;
    case (op)
      OP_SUB, OP_SUBI: f = ALU_SUB;
      OP_MUL, OP_MULI: f = ALU_MUL;
      default:         f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cpu_sequencer_program_counter.sv
// Program counter: hold beats load beats increment; increment wraps naturally.
module program_counter #(
  parameter int unsigned PC_SIZE = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic               hold,
  input  logic [PC_SIZE-1:0] target,
  output logic [PC_SIZE-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (hold) begin
      pc <= pc;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_SIZE'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// picoMIPS control unit: two-cycle fetch/execute sequencer with branch-on-nonzero
// and a press/release handshake that adds the switches into a register once per press.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [N-1:0]       aluResult,
  input  logic               btnGo,
  output logic [PC_SIZE-1:0] pcOut,
  output logic               writeReg,
  output alu_func_t          aluFunc,
  output logic               aluImmediate,
  output logic               immSwitches,
  output logic [R_SIZE-1:0]  opD,
  output logic [N-1:0]       opS,
  output logic               halted,
  output logic               waitingInput
);

  seq_state_t state, state_next;
  instr_t     ir;
  logic       pc_load, pc_inc, pc_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH) ir <= instr_t'(instrIn);
    end
  end

  // Next state, pc control and datapath controls all decode from state + IR
  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_hold      = 1'b0;
    writeReg     = 1'b0;
    aluFunc      = ALU_ADD;
    aluImmediate = 1'b0;
    immSwitches  = 1'b0;
    halted       = 1'b0;
    waitingInput = 1'b0;
    case (state)
      FETCH: state_next = EXECUTE;
      EXECUTE: begin
        state_next = FETCH;
        case (ir.op)
          OP_ADD, OP_SUB, OP_MUL: begin
            writeReg = 1'b1;
            aluFunc  = alu_func_of(ir.op);
            pc_inc   = 1'b1;
          end
          OP_ADDI, OP_SUBI, OP_MULI: begin
            writeReg     = 1'b1;
            aluFunc      = alu_func_of(ir.op);
            aluImmediate = 1'b1;
            pc_inc       = 1'b1;
          end
          OP_ADDSW: state_next = WAIT_PRESS;
          OP_BNZ: begin
            // aluResult = rd + imm, so it differs from imm exactly when rd is nonzero
            aluImmediate = 1'b1;
            if (aluResult != ir.imm) pc_load = 1'b1;
            else                     pc_inc  = 1'b1;
          end
          OP_JMP: pc_load = 1'b1;
          OP_HALT: begin
            state_next = HALT;
            halted     = 1'b1;
            pc_hold    = 1'b1;
          end
          default: pc_inc = 1'b1;
        endcase
      end
      WAIT_PRESS: begin
        waitingInput = 1'b1;
        if (btnGo) begin
          writeReg     = 1'b1;
          aluImmediate = 1'b1;
          immSwitches  = 1'b1;
          state_next   = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!btnGo) begin
          pc_inc     = 1'b1;
          state_next = FETCH;
        end
      end
      HALT: begin
        halted  = 1'b1;
        pc_hold = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  assign opD = ir.rd;
  assign opS = ir.imm;

  program_counter #(.PC_SIZE(PC_SIZE)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .inc    (pc_inc),
    .hold   (pc_hold),
    .target (ir.imm[PC_SIZE-1:0]),
    .pc     (pcOut)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: ROM + register-file datapath around the DUT, an
// instruction-level reference model feeding a write scoreboard, directed timing checks.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] val;
    logic       imm;
    logic       sw;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] instrIn;
  logic [7:0]  aluResult;
  logic        btnGo;
  logic [4:0]  pcOut;
  logic        writeReg;
  alu_func_t   aluFunc;
  logic        aluImmediate;
  logic        immSwitches;
  logic [2:0]  opD;
  logic [7:0]  opS;
  logic        halted;
  logic        waitingInput;

  logic [14:0] rom [32];
  logic [7:0]  regs [8];
  logic [7:0]  sw = 8'h00;
  logic [7:0]  b_op, result;
  logic        rand_btn = 1'b0;
  logic        btn_rand = 1'b0;
  logic        btn_dir = 1'b0;

  wr_t         exp_q [$];
  wr_t         mon_e;
  int          compared = 0;
  int          mismatched = 0;
  int          model_pc;
  logic        model_done;
  int          t3_pc [13] = '{0, 0, 1, 1, 2, 2, 31, 31, 0, 0, 5, 5, 5};

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instrIn      (instrIn),
    .aluResult    (aluResult),
    .btnGo        (btnGo),
    .pcOut        (pcOut),
    .writeReg     (writeReg),
    .aluFunc      (aluFunc),
    .aluImmediate (aluImmediate),
    .immSwitches  (immSwitches),
    .opD          (opD),
    .opS          (opS),
    .halted       (halted),
    .waitingInput (waitingInput)
  );

  assign instrIn = rom[pcOut];
  assign btnGo   = rand_btn ? btn_rand : btn_dir;

  // Datapath environment: register file and ALU driven by the DUT's controls
  always_comb begin
    b_op = aluImmediate ? (immSwitches ? sw : opS) : regs[opS[2:0]];
    case (aluFunc)
      ALU_SUB: result = regs[opD] - b_op;
      ALU_MUL: result = regs[opD] * b_op;
      default: result = regs[opD] + b_op;
    endcase
  end
  assign aluResult = result;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (writeReg) begin
      regs[opD] <= result;
    end
  end

  always @(posedge clk) begin
    #2;
    if ($urandom_range(0, 2) == 0) btn_rand = ~btn_rand;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every register write must match the next modelled write
  always @(negedge clk) begin
    if (!reset && writeReg === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got write r%0d=%0d, expected no write", opD, result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_rd", int'(opD), int'(mon_e.rd));
        chk("write_val", int'(result), int'(mon_e.val));
        chk("write_imm", int'(aluImmediate), int'(mon_e.imm));
        chk("write_sw", int'(immSwitches), int'(mon_e.sw));
      end
    end
  end

  function automatic logic [14:0] ins(input int op, input int rd, input int imm);
    logic [3:0] o;
    logic [2:0] r;
    logic [7:0] i;
    o = 4'(op);
    r = 3'(rd);
    i = 8'(imm);
    return {o, r, i};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = ins(OP_HALT, 0, 0);
  endtask

  // Instruction-level reference: executes the ROM and records every register write
  task automatic run_model(input logic [7:0] swv);
    logic [7:0] r [8];
    int pc;
    logic [3:0] op;
    logic [2:0] rd;
    logic [7:0] imm, b;
    wr_t w;
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    pc = 0;
    exp_q.delete();
    model_done = 1'b0;
    model_pc = -1;
    sw = swv;
    for (int s = 0; s < 500 && !model_done; s++) begin
      {op, rd, imm} = rom[pc];
      if (op >= 1 && op <= 6) begin
        b = (op % 2 == 0) ? imm : r[imm[2:0]];
        if (op <= 2)      r[rd] = r[rd] + b;
        else if (op <= 4) r[rd] = r[rd] - b;
        else              r[rd] = r[rd] * b;
        w = '{rd: rd, val: r[rd], imm: (op % 2 == 0), sw: 1'b0};
        exp_q.push_back(w);
        pc = (pc + 1) % 32;
      end else if (op == 7) begin
        r[rd] = r[rd] + swv;
        w = '{rd: rd, val: r[rd], imm: 1'b1, sw: 1'b1};
        exp_q.push_back(w);
        pc = (pc + 1) % 32;
      end else if (op == 8) begin
        pc = (r[rd] != 0) ? int'(imm[4:0]) : (pc + 1) % 32;
      end else if (op == 9) begin
        pc = int'(imm[4:0]);
      end else if (op == 15) begin
        model_pc = pc;
        model_done = 1'b1;
      end else begin
        pc = (pc + 1) % 32;
      end
    end
  endtask

  // Entered 2 time units after a rising edge; leaves cycle 1 about to be sampled
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k;
    int len, op, imm;
    bit done;
    clear_rom();
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    next_cycle();

    // Test 1: reset values, IR latch, reset inside WAIT_RELEASE
    clear_rom();
    rom[0] = ins(OP_ADDI, 1, 1);
    rom[1] = ins(OP_ADDSW, 2, 0);
    run_model(8'h11);
    btn_dir = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pcOut, 0);
    chk("rst_wr", writeReg, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wait", waitingInput, 0);
    chk("rst_alufunc", aluFunc, ALU_ADD);
    chk("rst_opS", opS, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t1_c1_pc", pcOut, 0);
        chk("t1_c1_wr", writeReg, 0);
        chk("t1_c1_opD", opD, 0);
      end
      if (k == 2) begin
        chk("t1_ir_opD", opD, 1);
        chk("t1_ir_opS", opS, 1);
      end
      if (k == 6) begin
        chk("t1_release_pc", pcOut, 1);
        chk("t1_release_wait", waitingInput, 0);
        chk("t1_release_wr", writeReg, 0);
      end
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t1_midrst_pc", pcOut, 0);
    chk("t1_midrst_wait", waitingInput, 0);
    chk("t1_pending", exp_q.size(), 0);
    next_cycle();
    btn_dir = 1'b0;

    // Test 2: ADDI r1,5; ADD r1,r1; HALT
    clear_rom();
    rom[0] = ins(OP_ADDI, 1, 5);
    rom[1] = ins(OP_ADD, 1, 1);
    run_model(8'h00);
    do_reset();
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t2_wr", writeReg, (k == 2 || k == 4) ? 1 : 0);
      if (k == 2) chk("t2_imm_c2", aluImmediate, 1);
      if (k == 4) chk("t2_imm_c4", aluImmediate, 0);
      chk("t2_halted", halted, (k >= 6) ? 1 : 0);
      chk("t2_pc", pcOut, (k <= 2) ? 0 : (k <= 4) ? 1 : 2);
      next_cycle();
    end
    chk("t2_r1", regs[1], 10);
    chk("t2_pending", exp_q.size(), 0);

    // Test 3: BNZ not taken, taken to 31, wrap to 0
    clear_rom();
    rom[0]  = ins(OP_BNZ, 2, 5);
    rom[1]  = ins(OP_ADDI, 2, 3);
    rom[2]  = ins(OP_BNZ, 2, 31);
    rom[31] = ins(OP_ADDI, 4, 1);
    run_model(8'h00);
    do_reset();
    for (k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk("t3_pc", pcOut, t3_pc[k-1]);
      next_cycle();
    end
    chk("t3_halted", halted, 1);
    chk("t3_pending", exp_q.size(), 0);

    // Test 4: ADDSW r3 with a slow press
    clear_rom();
    rom[0] = ins(OP_ADDI, 3, 7);
    rom[1] = ins(OP_ADDSW, 3, 0);
    run_model(8'h2A);
    do_reset();
    for (k = 1; k <= 16; k++) begin
      btn_dir = (k >= 10 && k <= 13);
      @(negedge clk);
      chk("t4_wait", waitingInput, (k >= 5 && k <= 10) ? 1 : 0);
      chk("t4_wr", writeReg, (k == 2 || k == 10) ? 1 : 0);
      chk("t4_immsw", immSwitches, (k == 10) ? 1 : 0);
      chk("t4_pc", pcOut, (k <= 2) ? 0 : (k <= 14) ? 1 : 2);
      next_cycle();
    end
    chk("t4_r3", regs[3], 8'h31);
    chk("t4_pending", exp_q.size(), 0);

    // Test 5: ADDSW entered with the button already held
    clear_rom();
    rom[0] = ins(OP_ADDSW, 5, 0);
    run_model(8'h2A);
    do_reset();
    for (k = 1; k <= 8; k++) begin
      btn_dir = (k <= 5);
      @(negedge clk);
      chk("t5_wr", writeReg, (k == 3) ? 1 : 0);
      chk("t5_pc", pcOut, (k <= 6) ? 0 : 1);
      next_cycle();
    end
    btn_dir = 1'b0;
    chk("t5_r5", regs[5], 8'h2A);
    chk("t5_pending", exp_q.size(), 0);

    // Test 6: undefined opcode then JMP 4
    clear_rom();
    rom[0] = ins(12, 1, 7);
    rom[1] = ins(OP_JMP, 0, 4);
    rom[4] = ins(OP_ADDI, 6, 9);
    run_model(8'h00);
    do_reset();
    for (k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t6_wr", writeReg, (k == 6) ? 1 : 0);
      chk("t6_pc", pcOut, (k <= 2) ? 0 : (k <= 4) ? 1 : 4);
      next_cycle();
    end
    chk("t6_pending", exp_q.size(), 0);

    // Random forward-only programs with a randomly bouncing button
    rand_btn = 1'b1;
    for (int t = 0; t < 25; t++) begin
      clear_rom();
      len = $urandom_range(6, 31);
      for (int i = 0; i < len - 1; i++) begin
        op = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 14);
        imm = (op == 8 || op == 9) ? $urandom_range(i + 1, len - 1) : $urandom_range(0, 255);
        rom[i] = ins(op, $urandom_range(0, 7), imm);
      end
      run_model(8'($urandom_range(0, 255)));
      do_reset();
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        @(negedge clk);
        if (halted === 1'b1) done = 1'b1;
        else next_cycle();
      end
      if (!done) begin
        compared++;
        mismatched++;
        $display("FAIL rand_timeout: got no halt after 3000 cycles, expected halt at pc %0d", model_pc);
      end
      next_cycle();
      repeat (2) next_cycle();
      @(negedge clk);
      chk("rand_model_halts", int'(model_done), 1);
      chk("rand_halt_pc", pcOut, model_pc);
      chk("rand_pending", exp_q.size(), 0);
      next_cycle();
    end
    rand_btn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
